// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared state enum, data width and address-error check for mem_responder
package mem_resp_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  function automatic logic addr_err(input logic [DATA_W-1:0] addr, input int unsigned depth);
    return addr[1:0] != 2'b00 || {2'b00, addr[31:2]} >= depth;
  endfunction
endpackage

// File: rtl/mem_resp_array.sv
// mem_resp_array: single-port word storage (clk, en, we, addr, wdata -> rdata), synchronous read, no reset
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-state memory target; req_valid/req_write/req_addr/req_wdata -> req_ready, rsp_valid/rsp_rdata/rsp_err with rsp_ready, active-low sync reset
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t            state;
  logic [3:0]        cnt;
  logic [31:0]       addr_q, addr_s;
  logic [DATA_W-1:0] wdata_q, wdata_s, mem_rdata;
  logic              write_q, write_s, err_q, idle, enter_resp;
  assign idle    = state == IDLE;
  assign addr_s  = idle ? req_addr : addr_q;
  assign wdata_s = idle ? req_wdata : wdata_q;
  assign write_s = idle ? req_write : write_q;
  assign enter_resp = reset && (idle ? req_valid && WAIT_CYCLES == 0 : state == WAIT && cnt == 4'd1);
  mem_resp_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk  (clk),
    .en   (enter_resp && !addr_err(addr_s, DEPTH_WORDS)),
    .we   (write_s),
    .addr (addr_s[AW+1:2]),
    .wdata(wdata_s),
    .rdata(mem_rdata)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else
      case (state)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          write_q <= req_write;
          err_q   <= addr_err(req_addr, DEPTH_WORDS);
          cnt     <= 4'(WAIT_CYCLES);
          state   <= WAIT_CYCLES == 0 ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
  assign req_ready = reset && idle;
  assign rsp_valid = reset && state == RESP;
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = rsp_valid && !err_q && !write_q ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench for mem_responder (WAIT_CYCLES=2) plus a zero-wait instance
module tb_mem_responder;
  localparam int DEPTH = 256;
  localparam int W = 2;
  logic clk = 1'b0, reset = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, rsp_rdata;
  logic req_ready, rsp_valid, rsp_err;
  logic r0_req_valid = 1'b0, r0_req_write = 1'b0, r0_rsp_ready = 1'b0;
  logic [31:0] r0_req_addr = '0, r0_req_wdata = '0, r0_rsp_rdata;
  logic r0_req_ready, r0_rsp_valid, r0_rsp_err;
  int n_cmp = 0, n_fail = 0, cyc = 0, hold_n = 0;
  typedef struct {logic [31:0] rdata; logic err; int acc;} exp_t;
  exp_t q[$];
  logic [31:0] mem_m [int];
  logic prev_hold = 1'b0, exp_idle = 1'b0;
  logic [31:0] prev_rdata = '0;
  logic prev_err = 1'b0;

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(r0_req_valid), .req_write(r0_req_write),
    .req_addr(r0_req_addr), .req_wdata(r0_req_wdata), .req_ready(r0_req_ready),
    .rsp_valid(r0_rsp_valid), .rsp_ready(r0_rsp_ready), .rsp_rdata(r0_rsp_rdata), .rsp_err(r0_rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: errors never touch storage, stores update the word, loads return it.
  function automatic exp_t model(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int idx;
    idx = int'(a >> 2);
    e.acc = 0;
    e.err = (a % 4 != 0) || (a / 4 >= DEPTH);
    e.rdata = 0;
    if (!e.err && w) mem_m[idx] = d;
    else if (!e.err) e.rdata = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
    return e;
  endfunction

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 100 cycles");
      req_valid = 1'b0;
      return;
    end
    e = model(w, a, d);
    e.acc = cyc;
    q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_write = $urandom_range(0, 1) == 1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid && hold_n > 0) begin
      rsp_ready = 1'b0;
      hold_n--;
    end else rsp_ready = $urandom_range(0, 3) != 0;
    if (!reset) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      prev_hold = 1'b0;
      exp_idle = 1'b0;
    end else begin
      if (exp_idle) begin
        chk("idle_after_hs_ready", req_ready, 1);
        chk("idle_after_hs_valid", rsp_valid, 0);
        exp_idle = 1'b0;
      end
      if (rsp_valid) begin
        chk("busy_req_ready", req_ready, 0);
        if (q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response pending");
        end else if (!prev_hold) chk("latency", cyc - q[0].acc, 1 + W);
        else begin
          chk("stable_rdata", rsp_rdata, prev_rdata);
          chk("stable_err", rsp_err, prev_err);
        end
        if (rsp_ready && q.size() != 0) begin
          e = q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", rsp_err, e.err);
          exp_idle = 1'b1;
        end
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_rdata = rsp_rdata;
      prev_err = rsp_err;
    end
  end

  initial begin
    logic [31:0] a, v0;
    int r;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1 chk("ready_after_reset", req_ready, 1);
    for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), $urandom);
    issue(1'b1, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 32'h10, 32'h0);
    issue(1'b0, 32'h13, 32'h0);
    issue(1'b1, 32'h400, 32'hCAFEF00D);
    issue(1'b0, 32'h0, 32'h0);
    drain();
    hold_n = 4;
    issue(1'b0, 32'h10, 32'h0);
    drain();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    chk("abort_accept_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 chk("ready_after_abort", req_ready, 1);
    issue(1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) a = 32'($urandom_range(0, 15)) << 2;
      else if (r < 8) a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
      else a = 32'($urandom_range(DEPTH, 32'h3FFF_FFFF)) << 2;
      issue($urandom_range(0, 1) == 1, a, $urandom);
    end
    drain();
    v0 = $urandom;
    @(negedge clk);
    r0_rsp_ready = 1'b1; r0_req_valid = 1'b1; r0_req_write = 1'b1; r0_req_addr = 32'hC; r0_req_wdata = v0;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        chk("w0_req_ready", r0_req_ready, 1);
        chk("w0_idle_valid", r0_rsp_valid, 0);
      end else begin
        chk("w0_rsp_valid", r0_rsp_valid, 1);
        chk("w0_busy_ready", r0_req_ready, 0);
        chk("w0_rsp_rdata", r0_rsp_rdata, i == 1 ? 32'h0 : v0);
        chk("w0_rsp_err", r0_rsp_err, 0);
      end
      @(posedge clk);
      #1 if (i == 0) r0_req_write = 1'b0;
      @(negedge clk);
    end
    r0_req_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
